// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite position controller: samples buttons on the vsync
// falling edge and commits clamped X/Y inside blanking. Define SPRITE_WRAP_EN to wrap.
module sprite_motion_ctrl #(
   parameter int SCREEN_W        = 640,
   parameter int SCREEN_H        = 480,
   parameter int SPRITE_W        = 50,
   parameter int SPRITE_H        = 50,
   parameter int STEP            = 1,
   parameter int FRAMES_PER_MOVE = 2,
   parameter int INIT_X          = 40,
   parameter int INIT_Y          = 1
) (
   input  logic        iVGA_CLK,
   input  logic        iRST,
   input  logic        iVS,
   input  logic        mLeft,
   input  logic        mRight,
   input  logic        mUp,
   input  logic        mDown,
   input  logic        iHold,
   output logic [9:0]  oPosX,
   output logic [8:0]  oPosY,
   output logic        oUpdate,
   output logic [15:0] oFrameCnt
);
   localparam logic signed [11:0] MAX_X  = 12'(SCREEN_W - SPRITE_W);
   localparam logic signed [11:0] MAX_Y  = 12'(SCREEN_H - SPRITE_H);
   localparam logic signed [11:0] STEP_S = 12'(STEP);
   localparam int                 PRE_W  = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
   localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(FRAMES_PER_MOVE - 1);

   typedef enum logic [1:0] {IDLE, SAMPLE, CALC, COMMIT} state_t;

   state_t             state;
   logic [3:0]         sync1, sync2;   // {left, right, up, down}, active-low
   logic               vs_prev;
   logic [PRE_W-1:0]   presc;
   logic               dir_l, dir_r, dir_u, dir_d;
   logic [9:0]         next_x;
   logic [8:0]         next_y;
   logic               frame_edge;
   logic signed [11:0] dx, dy, sum_x, sum_y;
   logic [9:0]         lim_x;
   logic [8:0]         lim_y;

   assign frame_edge = vs_prev & ~iVS;

   always_comb begin
      dx = '0;
      dy = '0;
      if (dir_r && !dir_l) dx = STEP_S;
      else if (dir_l && !dir_r) dx = -STEP_S;
      if (dir_d && !dir_u) dy = STEP_S;
      else if (dir_u && !dir_d) dy = -STEP_S;
      sum_x = $signed({2'b00, oPosX}) + dx;
      sum_y = $signed({3'b000, oPosY}) + dy;
   end

   // Out-of-range results either saturate at the edge or wrap to the far edge.
   always_comb begin
      lim_x = sum_x[9:0];
      lim_y = sum_y[8:0];
`ifdef SPRITE_WRAP_EN
      if (sum_x < 12'sd0)      lim_x = MAX_X[9:0];
      else if (sum_x > MAX_X)  lim_x = '0;
      if (sum_y < 12'sd0)      lim_y = MAX_Y[8:0];
      else if (sum_y > MAX_Y)  lim_y = '0;
`else
      if (sum_x < 12'sd0)      lim_x = '0;
      else if (sum_x > MAX_X)  lim_x = MAX_X[9:0];
      if (sum_y < 12'sd0)      lim_y = '0;
      else if (sum_y > MAX_Y)  lim_y = MAX_Y[8:0];
`endif
   end

   always_ff @(posedge iVGA_CLK or posedge iRST) begin
      if (iRST) begin
         state     <= IDLE;
         sync1     <= 4'hF;
         sync2     <= 4'hF;
         vs_prev   <= 1'b1;
         presc     <= '0;
         dir_l     <= 1'b0;
         dir_r     <= 1'b0;
         dir_u     <= 1'b0;
         dir_d     <= 1'b0;
         next_x    <= 10'(INIT_X);
         next_y    <= 9'(INIT_Y);
         oPosX     <= 10'(INIT_X);
         oPosY     <= 9'(INIT_Y);
         oUpdate   <= 1'b0;
         oFrameCnt <= '0;
      end else begin
         sync1   <= {mLeft, mRight, mUp, mDown};
         sync2   <= sync1;
         vs_prev <= iVS;
         oUpdate <= 1'b0;
         if (frame_edge) oFrameCnt <= oFrameCnt + 16'd1;
         case (state)
            IDLE: if (frame_edge) state <= SAMPLE;
            SAMPLE: begin
               {dir_l, dir_r, dir_u, dir_d} <= ~sync2;
               if (iHold) begin
                  presc <= '0;
                  state <= IDLE;
               end else if (presc != PRE_LAST) begin
                  presc <= presc + 1'b1;
                  state <= IDLE;
               end else begin
                  presc <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               next_x <= lim_x;
               next_y <= lim_y;
               state  <= COMMIT;
            end
            COMMIT: begin
               oPosX   <= next_x;
               oPosY   <= next_y;
               oUpdate <= (next_x != oPosX) || (next_y != oPosY);
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl; expected values worked out by hand
// for the default parameters (FRAMES_PER_MOVE=2, INIT 40/1).
module tb_sprite_motion_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vs = 1'b1;
   logic        left = 1'b1, right = 1'b1, up = 1'b1, down = 1'b1;
   logic        hold = 1'b0;
   logic [9:0]  pos_x;
   logic [8:0]  pos_y;
   logic        upd;
   logic [15:0] frame_cnt;

   int n_vec = 0;
   int n_err = 0;
   int p, f, tot;

   sprite_motion_ctrl dut (
      .iVGA_CLK (clk),
      .iRST     (rst),
      .iVS      (vs),
      .mLeft    (left),
      .mRight   (right),
      .mUp      (up),
      .mDown    (down),
      .iHold    (hold),
      .oPosX    (pos_x),
      .oPosY    (pos_y),
      .oUpdate  (upd),
      .oFrameCnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      left = 1'b1; right = 1'b1; up = 1'b1; down = 1'b1;
      hold = 1'b0; vs = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // One frame: vsync high 4 cycles, low 12, high 4. Reports update pulses and
   // the cycle (counted from driving vsync low) at which the first one appeared.
   task automatic frame(output int pulses, output int first_at);
      pulses = 0;
      first_at = -1;
      repeat (4) tick();
      vs = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 13) vs = 1'b1;
         tick();
         if (upd === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = i;
         end
      end
   endtask

   initial begin
      // 1: idle frames after reset
      do_reset();
      chk("rst_x", pos_x, 40);
      chk("rst_y", pos_y, 1);
      chk("rst_upd", upd, 0);
      chk("rst_cnt", frame_cnt, 0);
      tot = 0;
      repeat (5) begin frame(p, f); tot += p; end
      chk("idle_pulses", tot, 0);
      chk("idle_x", pos_x, 40);
      chk("idle_y", pos_y, 1);
      chk("idle_cnt", frame_cnt, 5);

      // 2: right held 10 frames, move every 2nd frame, 4-cycle latency
      do_reset();
      right = 1'b0;
      tot = 0;
      for (int i = 1; i <= 10; i++) begin
         frame(p, f);
         tot += p;
         if (i % 2 == 0) chk("right_latency", f, 4);
         else chk("right_nomove", p, 0);
      end
      chk("right_pulses", tot, 5);
      chk("right_x", pos_x, 45);
      chk("right_y", pos_y, 1);

      // 3: up held into the top edge
      do_reset();
      up = 1'b0;
      frame(p, f);
      frame(p, f);
      chk("up_first_pulse", p, 1);
      chk("up_first_y", pos_y, 0);
      frame(p, f);
      frame(p, f);
`ifdef SPRITE_WRAP_EN
      chk("up_edge_pulse", p, 1);
      chk("up_edge_y", pos_y, 430);
`else
      chk("up_edge_pulse", p, 0);
      chk("up_edge_y", pos_y, 0);
`endif

      // 4: left+right cancel, down moves
      do_reset();
      left = 1'b0; right = 1'b0; down = 1'b0;
      tot = 0;
      repeat (4) begin frame(p, f); tot += p; end
      chk("lrd_x", pos_x, 40);
      chk("lrd_y", pos_y, 3);
      chk("lrd_pulses", tot, 2);

      // 5: hold freezes position, prescaler restarts after release
      do_reset();
      hold = 1'b1; right = 1'b0;
      tot = 0;
      repeat (6) begin frame(p, f); tot += p; end
      chk("hold_pulses", tot, 0);
      chk("hold_x", pos_x, 40);
      chk("hold_cnt", frame_cnt, 6);
      hold = 1'b0;
      frame(p, f);
      chk("rel_frame1", p, 0);
      frame(p, f);
      chk("rel_frame2", p, 1);
      chk("rel_x", pos_x, 41);

      // 6: reset during CALC aborts the commit
      do_reset();
      right = 1'b0;
      repeat (121) frame(p, f);
      chk("pre_abort_x", pos_x, 100);
      repeat (4) tick();
      vs = 1'b0;
      tick();              // frame edge seen, now in SAMPLE
      tick();              // now in CALC
      rst = 1'b1;
      #1;
      chk("abort_x", pos_x, 40);
      chk("abort_y", pos_y, 1);
      chk("abort_upd", upd, 0);
      chk("abort_cnt", frame_cnt, 0);
      tick();
      rst = 1'b0;
      vs = 1'b1;
      tot = 0;
      repeat (10) begin tick(); if (upd === 1'b1) tot++; end
      chk("abort_pulses", tot, 0);
      chk("abort_after_x", pos_x, 40);
      chk("abort_after_cnt", frame_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
